spi_read_master: RTL and testbench

- Parametrised SPI receive-only master for serial ADC/sensor peripherals.
- Drives CS and SCLK, shifts in SDO MSB-first, and discards a configurable number of leading bits.
- Presents each frame on a valid/ready output port.
- Frames start from a single-cycle request or from an internal auto-refresh timer. Replaces hand-built SCLK-edge controllers in board top levels.

---
 rtl/spi_read_master.sv | 188 ++++++++++++++++++
 tb/tb_spi_read_master.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_read_master.sv
// SPI receive-only master: drives CS/SCLK, shifts SDO in MSB-first, drops
// SKIP_BITS leading bits and presents each payload on a valid/ready port.
// Frames start from a one-cycle start request or an optional auto timer.
module spi_read_master #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SKIP_BITS   = 0,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned GAP_CYC     = 8,
    parameter int unsigned AUTO_PERIOD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_ready,
    input  logic              SDO,
    output logic              SCLK,
    output logic              CS,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              overrun
);

    localparam int unsigned NBITS = SKIP_BITS + DATA_W;
    localparam int unsigned BIT_W = $clog2(NBITS + 1);
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]        r_state;
    logic [DIV_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bit;
    logic [GAP_W-1:0]  r_gap;
    logic [DATA_W-1:0] r_shift;
    logic              r_sclk;
    logic              r_cs;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_overrun;

    logic              w_auto_tick;
    logic              w_trig;
    logic              w_keep;
    logic [DATA_W:0]   w_shift_ext;

    // One extra bit keeps the shift expression legal when DATA_W is 1.
    assign w_shift_ext = {r_shift, SDO};
    assign w_trig      = start | w_auto_tick;

    generate
        if (AUTO_PERIOD > 0) begin : g_auto
            localparam int unsigned AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
            localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);
            logic [AUTO_W-1:0] r_auto_cnt;

            // Free-running refresh counter; never pauses for frame activity.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_auto_cnt <= '0;
                end else if (r_auto_cnt == AUTO_LAST) begin
                    r_auto_cnt <= '0;
                end else begin
                    r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
                end
            end

            assign w_auto_tick = (r_auto_cnt == AUTO_LAST);
        end else begin : g_no_auto
            assign w_auto_tick = 1'b0;
        end

        if (SKIP_BITS == 0) begin : g_no_skip
            assign w_keep = 1'b1;
        end else begin : g_skip
            localparam logic [BIT_W-1:0] SKIP_LIM = BIT_W'(SKIP_BITS);
            assign w_keep = (r_bit >= SKIP_LIM);
        end
    endgenerate

    // Frame sequencer: SCLK/CS generation, sampling and output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_gap      <= '0;
            r_shift    <= '0;
            r_sclk     <= 1'b1;
            r_cs       <= 1'b1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            // A load in HOLD below overrides this consume.
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_state <= S_SETUP;
                        r_cs    <= 1'b0;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_shift <= '0;
                    end
                end

                S_SETUP: begin
                    if (r_div == DIV_LAST) begin
                        r_div   <= '0;
                        r_sclk  <= 1'b0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end

                S_SHIFT: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + DIV_W'(1);
                    end else begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            // Rising SCLK edge: capture SDO seen during the low half.
                            r_sclk <= 1'b1;
                            if (w_keep) begin
                                r_shift <= w_shift_ext[DATA_W-1:0];
                            end
                        end else if (r_bit == BIT_LAST) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_bit  <= r_bit + BIT_W'(1);
                            r_sclk <= 1'b0;
                        end
                    end
                end

                S_HOLD: begin
                    if (r_div == DIV_LAST) begin
                        r_div      <= '0;
                        r_cs       <= 1'b1;
                        r_rx_data  <= r_shift;
                        r_rx_valid <= 1'b1;
                        r_overrun  <= r_rx_valid && !rx_ready;
                        r_gap      <= '0;
                        r_state    <= S_GAP;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end

                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cs    <= 1'b1;
                    r_sclk  <= 1'b1;
                end
            endcase
        end
    end

    assign SCLK     = r_sclk;
    assign CS       = r_cs;
    assign busy     = (r_state != S_IDLE);
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_spi_read_master.sv
// Bench for spi_read_master: instance A is start-driven (16 bits, no skip),
// instance B is auto-triggered (12 bits, 3 skipped). A timeline model predicts
// CS/SCLK/busy/rx outputs per cycle from frame-start times and handshake rules.
module tb_spi_read_master;

    localparam int DW_A = 16, SK_A = 0, CD_A = 4, GP_A = 8, AP_A = 0;
    localparam int DW_B = 12, SK_B = 3, CD_B = 4, GP_B = 5, AP_B = 400;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0;
    logic [1:0] ready = 2'b11;
    logic [1:0] sdo = 2'b00;

    logic sclk_a, cs_a, busy_a, rxv_a, ov_a;
    logic sclk_b, cs_b, busy_b, rxv_b, ov_b;
    logic [DW_A-1:0] rxd_a;
    logic [DW_B-1:0] rxd_b;

    spi_read_master #(.DATA_W(DW_A), .SKIP_BITS(SK_A), .CLK_DIV(CD_A),
                      .GAP_CYC(GP_A), .AUTO_PERIOD(AP_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .rx_ready(ready[0]), .SDO(sdo[0]),
        .SCLK(sclk_a), .CS(cs_a), .busy(busy_a), .rx_data(rxd_a),
        .rx_valid(rxv_a), .overrun(ov_a));

    spi_read_master #(.DATA_W(DW_B), .SKIP_BITS(SK_B), .CLK_DIV(CD_B),
                      .GAP_CYC(GP_B), .AUTO_PERIOD(AP_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(1'b0), .rx_ready(ready[1]), .SDO(sdo[1]),
        .SCLK(sclk_b), .CS(cs_b), .busy(busy_b), .rx_data(rxd_b),
        .rx_valid(rxv_b), .overrun(ov_b));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Words the peripheral must send next, per instance (written by stimulus only).
    logic [31:0] forced [2][4];
    int          nforced [2];

    // Model / measurement state (written by the compare process only).
    int          mcnt [2];
    bit          trig_prev [2];
    bit          rdy_prev [2];
    int          acnt [2];
    bit          mv [2];
    logic [31:0] md [2];
    logic [31:0] word [2];
    int          used [2];
    bit          p_cs [2], p_sclk [2], p_busy [2];
    int          lowc [2], rises [2], last_low [2], last_rises [2];
    int          last_gap [2], rise_obs [2], frames [2], ovc [2];
    int          last_fall [2], nint [2];
    bit          have_fall [2];
    int          obs;
    logic [31:0] first_b_data;
    int          first_b_rises;
    bit          first_b_done;

    // Peripheral state (written by the peripheral process only).
    int pidx [2];
    bit pp_sclk [2];

    function automatic int p_dw(int i); return (i == 0) ? DW_A : DW_B; endfunction
    function automatic int p_sk(int i); return (i == 0) ? SK_A : SK_B; endfunction
    function automatic int p_cd(int i); return (i == 0) ? CD_A : CD_B; endfunction
    function automatic int p_gp(int i); return (i == 0) ? GP_A : GP_B; endfunction
    function automatic int p_ap(int i); return (i == 0) ? AP_A : AP_B; endfunction

    function automatic logic [31:0] mask_of(int nb);
        logic [63:0] m;
        m = (64'd1 << nb) - 64'd1;
        return m[31:0];
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check1(string nm, logic act, logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_idle(string nm);
        bit seen;
        seen = busy_a;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (busy_a) seen = 1'b1;
            else if (seen) begin
                tick();
                return;
            end
        end
        check({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    // SPI peripheral: new bit after each SCLK fall, noise while SCLK is high.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic c, s;
                int nb;
                c  = (i == 0) ? cs_a : cs_b;
                s  = (i == 0) ? sclk_a : sclk_b;
                nb = p_dw(i) + p_sk(i);
                if (c) begin
                    pidx[i] = 0;
                    sdo[i]  = 1'($urandom % 2);
                end else if (!s && pp_sclk[i]) begin
                    if (pidx[i] < nb) sdo[i] = word[i][nb - 1 - pidx[i]];
                    else sdo[i] = 1'($urandom % 2);
                    pidx[i]++;
                end else if (s) begin
                    sdo[i] = 1'($urandom % 2);
                end
                pp_sclk[i] = s;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        forced[0][0] = 32'h0000_A5C3;
        forced[0][1] = 32'h0000_1234;
        forced[0][2] = 32'h0000_5678;
        nforced[0]   = 3;
        forced[1][0] = 32'h0000_0ABC;   // 3'b000 then 12'hABC
        nforced[1]   = 1;
        fork
            // ---------------- compare process ----------------
            begin
                forever begin
                    logic o_cs [2], o_sclk [2], o_busy [2], o_rxv [2], o_ov [2];
                    logic [31:0] o_rxd [2];
                    @(negedge clk);
                    obs++;
                    o_cs[0] = cs_a;     o_cs[1] = cs_b;
                    o_sclk[0] = sclk_a; o_sclk[1] = sclk_b;
                    o_busy[0] = busy_a; o_busy[1] = busy_b;
                    o_rxv[0] = rxv_a;   o_rxv[1] = rxv_b;
                    o_ov[0] = ov_a;     o_ov[1] = ov_b;
                    o_rxd[0] = 32'(rxd_a);
                    o_rxd[1] = 32'(rxd_b);
                    for (int i = 0; i < 2; i++) begin
                        string sf;
                        int nb, cd, gp, ap, len;
                        bit comp, e_cs, e_sclk, e_busy, e_ov;
                        sf  = (i == 0) ? "A" : "B";
                        nb  = p_dw(i) + p_sk(i);
                        cd  = p_cd(i);
                        gp  = p_gp(i);
                        ap  = p_ap(i);
                        len = cd * (2 * nb + 2);
                        if (rst) begin
                            mcnt[i] = 0; trig_prev[i] = 0; rdy_prev[i] = 0; acnt[i] = 0;
                            mv[i] = 0; md[i] = '0; have_fall[i] = 0; nint[i] = 0;
                            lowc[i] = 0; rises[i] = 0;
                            p_cs[i] = 1; p_sclk[i] = 1; p_busy[i] = 0;
                            check1({"rst_cs_", sf}, o_cs[i], 1'b1);
                            check1({"rst_sclk_", sf}, o_sclk[i], 1'b1);
                            check1({"rst_busy_", sf}, o_busy[i], 1'b0);
                            check1({"rst_rxv_", sf}, o_rxv[i], 1'b0);
                            check1({"rst_ov_", sf}, o_ov[i], 1'b0);
                            check({"rst_rxd_", sf}, o_rxd[i], 32'd0);
                        end else begin
                            // Frame timeline: mcnt = cycles since the accepted trigger.
                            if (mcnt[i] == 0) begin
                                if (trig_prev[i]) begin
                                    mcnt[i] = 1;
                                    if (used[i] < nforced[i]) begin
                                        word[i] = forced[i][used[i]];
                                        used[i]++;
                                    end else begin
                                        word[i] = $urandom & mask_of(nb);
                                    end
                                end
                            end else begin
                                mcnt[i]++;
                                if (mcnt[i] > len + gp) mcnt[i] = 0;
                            end
                            comp   = (mcnt[i] == len + 1);
                            e_cs   = !(mcnt[i] >= 1 && mcnt[i] <= len);
                            e_busy = (mcnt[i] != 0);
                            if (mcnt[i] >= cd + 1 && mcnt[i] <= cd + 2 * nb * cd)
                                e_sclk = (((mcnt[i] - 1 - cd) / cd) % 2) == 1;
                            else
                                e_sclk = 1'b1;
                            e_ov = comp && mv[i] && !rdy_prev[i];
                            if (comp) begin
                                mv[i] = 1'b1;
                                md[i] = word[i] & mask_of(p_dw(i));
                            end else if (mv[i] && rdy_prev[i]) begin
                                mv[i] = 1'b0;
                            end
                            check1({"cs_", sf}, o_cs[i], e_cs);
                            check1({"sclk_", sf}, o_sclk[i], e_sclk);
                            check1({"busy_", sf}, o_busy[i], e_busy);
                            check1({"rx_valid_", sf}, o_rxv[i], mv[i]);
                            check({"rx_data_", sf}, o_rxd[i], md[i]);
                            check1({"overrun_", sf}, o_ov[i], e_ov);

                            // Waveform measurements.
                            if (p_cs[i] && !o_cs[i]) begin
                                frames[i]++;
                                lowc[i] = 1;
                                rises[i] = 0;
                                if (ap > 0) begin
                                    if (have_fall[i]) begin
                                        check({"auto_interval_", sf}, obs - last_fall[i], ap);
                                        nint[i]++;
                                    end
                                    have_fall[i] = 1;
                                    last_fall[i] = obs;
                                end
                            end else if (!o_cs[i]) begin
                                lowc[i]++;
                            end
                            if (!o_cs[i] && o_sclk[i] && !p_sclk[i]) rises[i]++;
                            if (!p_cs[i] && o_cs[i]) begin
                                last_low[i]   = lowc[i];
                                last_rises[i] = rises[i];
                                rise_obs[i]   = obs;
                                if (i == 1 && !first_b_done) begin
                                    first_b_done  = 1;
                                    first_b_data  = o_rxd[1];
                                    first_b_rises = rises[1];
                                end
                            end
                            if (p_busy[i] && !o_busy[i]) last_gap[i] = obs - rise_obs[i];
                            if (o_ov[i]) ovc[i]++;
                            p_cs[i] = o_cs[i]; p_sclk[i] = o_sclk[i]; p_busy[i] = o_busy[i];

                            // Inputs that the next rising edge will sample.
                            trig_prev[i] = ((i == 0) ? start_a : 1'b0) |
                                           (ap > 0 && acnt[i] == ap - 1);
                            if (ap > 0) acnt[i] = (acnt[i] + 1) % ap;
                            rdy_prev[i] = ready[i];
                        end
                    end
                end
            end
            // ---------------- stimulus ----------------
            begin
                #1 rst = 1'b1;
                tick(); tick(); tick();
                rst = 1'b0;
                ready[0] = 1'b0;
                tick(); tick();

                // Directed frame 0xA5C3.
                pulse_start();
                wait_idle("frame1");
                check("a5c3_rx_data", 32'(rxd_a), 32'h0000_A5C3);
                check1("a5c3_rx_valid", rxv_a, 1'b1);
                check("a5c3_sclk_rises", last_rises[0], 32'd16);
                check("a5c3_cs_low_cycles", last_low[0], 32'd136);
                check("a5c3_busy_after_cs", last_gap[0], 32'd8);
                check("a5c3_overruns", ovc[0], 32'd0);

                // Consume, then two frames with rx_ready low; extra starts dropped.
                ready[0] = 1'b1;
                tick();
                check1("consume_clears_valid", rxv_a, 1'b0);
                ready[0] = 1'b0;
                pulse_start();
                for (int k = 0; k < 60; k++) tick();
                pulse_start();                         // during SHIFT
                for (int k = 0; k < 300 && !cs_a; k++) tick();
                tick(); tick(); tick();
                pulse_start();                         // during GAP
                wait_idle("frame2");
                check("dropped_starts_frames", frames[0], 32'd2);
                check("f1234_busy_after_cs", last_gap[0], 32'd8);
                check("f1234_rx_data", 32'(rxd_a), 32'h0000_1234);
                pulse_start();
                wait_idle("frame3");
                check("overrun_count", ovc[0], 32'd1);
                check("f5678_rx_data", 32'(rxd_a), 32'h0000_5678);
                check1("f5678_rx_valid", rxv_a, 1'b1);
                ready[0] = 1'b1;
                tick();
                check1("late_consume_clears_valid", rxv_a, 1'b0);

                // Randomized start/ready traffic, checked against the model.
                for (int k = 0; k < 3000; k++) begin
                    start_a  = ($urandom % 20) == 0;
                    ready[0] = 1'($urandom % 2);
                    tick();
                end
                start_a  = 1'b0;
                ready[0] = 1'b0;
                tick();
                if (busy_a) wait_idle("random_drain");

                // Leave data unconsumed, then reset in the middle of SHIFT.
                pulse_start();
                wait_idle("pre_reset");
                check1("pre_reset_rx_valid", rxv_a, 1'b1);
                pulse_start();
                begin
                    bit hit;
                    hit = 1'b0;
                    for (int k = 0; k < 300; k++) begin
                        tick();
                        if (rises[0] == 7) begin
                            hit = 1'b1;
                            break;
                        end
                    end
                    check1("reach_bit7", hit, 1'b1);
                end
                #1 rst = 1'b1;
                #1;
                check1("async_rst_cs", cs_a, 1'b1);
                check1("async_rst_sclk", sclk_a, 1'b1);
                check1("async_rst_rx_valid", rxv_a, 1'b0);
                check1("async_rst_busy", busy_a, 1'b0);
                check("async_rst_rx_data", 32'(rxd_a), 32'd0);
                tick(); tick();
                rst = 1'b0;
                tick();

                // Clean frame after the aborted one.
                forced[0][3] = 32'h0000_3C5A;
                nforced[0]   = 4;
                pulse_start();
                wait_idle("post_reset");
                check("post_reset_rx_data", 32'(rxd_a), 32'h0000_3C5A);
                check("post_reset_rises", last_rises[0], 32'd16);
                check("post_reset_cs_low", last_low[0], 32'd136);

                // Let the auto-triggered instance run at least five periods.
                for (int k = 0; k < 3000 && nint[1] < 5; k++) tick();
                check1("auto_five_periods", nint[1] >= 5, 1'b1);
                check1("skip_first_done", first_b_done, 1'b1);
                check("skip_rx_data", first_b_data, 32'h0000_0ABC);
                check("skip_sclk_rises", first_b_rises, 32'd15);

                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        join_any
    end

endmodule
